// File: rtl/scaler_h_lin.sv
// scaler_h_lin: multi-channel horizontal linear-interpolation scaler, 4.12 input step per output pixel.
// Define SCALER_H_LIN_ROUND_EN to round half up instead of truncating.
module scaler_h_lin #(
  parameter int DATA_WIDTH    = 8,
  parameter int CH_COUNT      = 3,
  parameter int PIXEL_STEP    = 4096,
  parameter int COE_WIDTH     = 10,
  parameter int LINE_SIZE_MAX = 4096
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [15:0]                        scale_step,
  input  logic [DATA_WIDTH*CH_COUNT-1:0]     di_i,
  input  logic                               de_i,
  input  logic                               hs_i,
  input  logic                               vs_i,
  output logic [DATA_WIDTH*CH_COUNT-1:0]     do_o,
  output logic                               de_o,
  output logic                               hs_o,
  output logic                               vs_o,
  output logic [$clog2(LINE_SIZE_MAX+1)-1:0] pix_count_o,
  output logic                               ovf_o
);
  localparam int PW = DATA_WIDTH * CH_COUNT;
  localparam int CW = $clog2(LINE_SIZE_MAX + 1);
  localparam int MW = DATA_WIDTH + COE_WIDTH + 1;
  localparam logic [16:0] ONE = 17'(PIXEL_STEP);
  localparam logic [15:0] STEP_MIN = 16'(PIXEL_STEP / 16);
`ifdef SCALER_H_LIN_ROUND_EN
  localparam logic [MW-1:0] RND = MW'(2 ** (COE_WIDTH - 1));
`else
  localparam logic [MW-1:0] RND = '0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, EMIT, FLUSH} state_t;
  state_t state;
  logic [16:0] acc, acc_n;
  logic [15:0] step, step_c;
  logic [PW-1:0] p0, p1;
  logic hs_d, vs_d, armed, flush_req, first;
  logic issue, done, over, hs_rise;
  logic [CW-1:0] cnt, cnt_n;
  logic [COE_WIDTH-1:0] c;
  assign step_c = scale_step < STEP_MIN ? STEP_MIN : scale_step;
  assign acc_n = acc + {1'b0, step};
  assign issue = state == EMIT || state == FLUSH;
  assign done = acc_n >= ONE;
  assign over = acc >= ONE;
  assign hs_rise = hs_i & ~hs_d;
  assign cnt_n = cnt == CW'(LINE_SIZE_MAX) ? cnt : cnt + CW'(1);
  assign c = acc[11 -: COE_WIDTH];
  // armed blocks a line that was already in progress when reset released
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      acc <= '0;
      step <= '0;
      p0 <= '0;
      p1 <= '0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      armed <= 1'b0;
      flush_req <= 1'b0;
      first <= 1'b0;
      cnt <= '0;
      pix_count_o <= '0;
      ovf_o <= 1'b0;
    end else begin
      hs_d <= hs_i;
      vs_d <= vs_i;
      armed <= armed | hs_i;
      flush_req <= flush_req | hs_rise;
      ovf_o <= (ovf_o & ~(vs_i & ~vs_d)) | (de_i & issue);
      if (issue) begin
        cnt <= cnt_n;
        first <= 1'b0;
      end
      case (state)
        IDLE: begin
          flush_req <= de_i & armed & hs_rise;
          if (de_i && armed) begin
            p0 <= di_i;
            acc <= '0;
            step <= step_c;
            cnt <= '0;
            first <= 1'b1;
            state <= RUN;
          end
        end
        RUN:
          if (de_i) begin
            if (over) begin
              acc <= acc - ONE;
              p0 <= di_i;
            end else begin
              p1 <= di_i;
              state <= EMIT;
            end
          end else if (flush_req || hs_rise) begin
            flush_req <= 1'b0;
            p1 <= p0;
            pix_count_o <= over ? cnt : pix_count_o;
            state <= over ? IDLE : FLUSH;
          end
        EMIT: begin
          acc <= done ? acc_n - ONE : acc_n;
          if (done) begin
            p0 <= p1;
            state <= RUN;
          end
        end
        FLUSH: begin
          acc <= acc_n;
          if (done) begin
            pix_count_o <= cnt_n;
            state <= IDLE;
          end
        end
      endcase
    end
  logic s1_v, s1_first, s1_last, s2_v, s2_first, s2_last, s3_v, s3_first, s3_last, last_o;
  logic [PW-1:0] s1_p0, s1_p1;
  logic [COE_WIDTH-1:0] s1_c;
  logic [MW-1:0] w0, w1;
  logic [MW-1:0] m0 [CH_COUNT];
  logic [MW-1:0] m1 [CH_COUNT];
  logic [MW-1:0] sum [CH_COUNT];
  logic [2:0] vs_sr;
  assign w1 = MW'(s1_c);
  assign w0 = MW'(2 ** COE_WIDTH) - w1;
  assign vs_o = vs_sr[2];
  // issue register, multiply, sum, then shift into the output register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {s1_v, s1_first, s1_last, s2_v, s2_first, s2_last, s3_v, s3_first, s3_last} <= '0;
      s1_p0 <= '0;
      s1_p1 <= '0;
      s1_c <= '0;
      for (int k = 0; k < CH_COUNT; k++) begin
        m0[k] <= '0;
        m1[k] <= '0;
        sum[k] <= '0;
      end
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b1;
      last_o <= 1'b0;
      vs_sr <= '1;
    end else begin
      s1_v <= issue;
      s1_first <= issue & first;
      s1_last <= state == FLUSH && done;
      s1_p0 <= p0;
      s1_p1 <= p1;
      s1_c <= c;
      {s2_v, s2_first, s2_last} <= {s1_v, s1_first, s1_last};
      {s3_v, s3_first, s3_last} <= {s2_v, s2_first, s2_last};
      for (int k = 0; k < CH_COUNT; k++) begin
        m0[k] <= MW'(s1_p0[k*DATA_WIDTH +: DATA_WIDTH]) * w0;
        m1[k] <= MW'(s1_p1[k*DATA_WIDTH +: DATA_WIDTH]) * w1;
        sum[k] <= m0[k] + m1[k] + RND;
        do_o[k*DATA_WIDTH +: DATA_WIDTH] <= sum[k][COE_WIDTH +: DATA_WIDTH];
      end
      de_o <= s3_v;
      last_o <= s3_v & s3_last;
      hs_o <= s3_first ? 1'b0 : last_o ? 1'b1 : hs_o;
      vs_sr <= {vs_sr[1:0], vs_i};
    end
endmodule

// File: tb/tb_scaler_h_lin.sv
// tb_scaler_h_lin: directed self-checking bench for scaler_h_lin.
module tb_scaler_h_lin;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] scale_step = 16'd4096;
  logic [23:0] di_i = '0;
  logic de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b1;
  logic [23:0] do_o;
  logic de_o, hs_o, vs_o, ovf_o;
  logic [12:0] pix_count_o;
  int total = 0, bad = 0, hs_err = 0;
  int xs [64];
  logic [23:0] q [$];
`ifdef SCALER_H_LIN_ROUND_EN
  localparam int RND = 512;
`else
  localparam int RND = 0;
`endif

  scaler_h_lin dut (
    .clk(clk), .rst(rst), .scale_step(scale_step), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .pix_count_o(pix_count_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (de_o) begin
      q.push_back(do_o);
      if (hs_o !== 1'b0) hs_err++;
    end
  end

  function automatic logic [23:0] pix(input int x);
    return {8'(x >> 1), 8'(255 - x), 8'(x)};
  endfunction

  function automatic logic [23:0] model(input int n, input int st, input int k);
    int pos, i, j, c;
    logic [23:0] a, b, r;
    pos = k * st;
    i = pos / 4096;
    c = (pos % 4096) / 4;
    j = (i + 1 < n) ? i + 1 : n - 1;
    a = pix(xs[i]);
    b = pix(xs[j]);
    r = '0;
    for (int h = 0; h < 3; h++)
      r[h*8 +: 8] = 8'((int'(a[h*8 +: 8]) * (1024 - c) + int'(b[h*8 +: 8]) * c + RND) / 1024);
    return r;
  endfunction

  task automatic run_line(input int n, input logic [15:0] st, input int gap);
    q.delete();
    scale_step = st;
    @(negedge clk);
    hs_i = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      di_i = pix(xs[i]);
      de_i = 1'b1;
      @(negedge clk);
      de_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    hs_i = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (do_o !== 24'h0) begin bad++; $display("FAIL reset_do got=%h want=0", do_o); end
    total++; if (de_o !== 1'b0) begin bad++; $display("FAIL reset_de got=%b want=0", de_o); end
    total++; if (hs_o !== 1'b1) begin bad++; $display("FAIL reset_hs got=%b want=1", hs_o); end
    total++; if (vs_o !== 1'b1) begin bad++; $display("FAIL reset_vs got=%b want=1", vs_o); end
    total++; if (pix_count_o !== 13'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", pix_count_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf_o); end
    rst = 1'b1;
    vs_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_latency;
    int k;
    q.delete();
    scale_step = 16'd4096;
    hs_i = 1'b0;
    repeat (2) @(negedge clk);
    di_i = pix(0);
    de_i = 1'b1;
    @(negedge clk);
    de_i = 1'b0;
    @(negedge clk);
    di_i = pix(100);
    de_i = 1'b1;
    @(posedge clk);
    #1 de_i = 1'b0;
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1 k++;
      if (de_o) break;
    end
    total++; if (k !== 4) begin bad++; $display("FAIL latency got=%0d want=4", k); end
    total++; if (hs_o !== 1'b0) begin bad++; $display("FAIL latency_hs got=%b want=0", hs_o); end
    @(negedge clk);
    hs_i = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (q.size() !== 2) begin bad++; $display("FAIL latency_count got=%0d want=2", q.size()); end
    total++; if (hs_o !== 1'b1) begin bad++; $display("FAIL latency_hs_end got=%b want=1", hs_o); end
  endtask

  task automatic test_ramp;
    for (int i = 0; i < 25; i++) xs[i] = i;
    run_line(25, 16'd4096, 1);
    total++; if (q.size() !== 25) begin bad++; $display("FAIL ramp_count got=%0d want=25", q.size()); end
    for (int k = 0; k < 25 && k < q.size(); k++) begin
      total++; if (q[k] !== pix(k)) begin bad++; $display("FAIL ramp_pix[%0d] got=%h want=%h", k, q[k], pix(k)); end
    end
    total++; if (int'(pix_count_o) !== 25) begin bad++; $display("FAIL ramp_pix_count got=%0d want=25", pix_count_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ramp_ovf got=%b want=0", ovf_o); end
    total++; if (hs_err !== 0) begin bad++; $display("FAIL ramp_hs_during_de got=%0d want=0", hs_err); end
    total++; if (hs_o !== 1'b1 || de_o !== 1'b0) begin bad++; $display("FAIL ramp_idle got=%b%b want=10", hs_o, de_o); end
  endtask

  task automatic test_downscale;
    for (int i = 0; i < 25; i++) xs[i] = 10 * i;
    run_line(25, 16'd8192, 3);
    total++; if (q.size() !== 13) begin bad++; $display("FAIL down_count got=%0d want=13", q.size()); end
    for (int k = 0; k < 13 && k < q.size(); k++) begin
      total++; if (q[k] !== pix(20 * k)) begin bad++; $display("FAIL down_pix[%0d] got=%h want=%h", k, q[k], pix(20 * k)); end
    end
    total++; if (int'(pix_count_o) !== 13) begin bad++; $display("FAIL down_pix_count got=%0d want=13", pix_count_o); end
  endtask

  task automatic test_delta;
    for (int i = 0; i < 25; i++) xs[i] = (i == 12) ? 255 : 0;
    run_line(25, 16'd2867, 3);
    total++; if (q.size() !== 36) begin bad++; $display("FAIL delta_count got=%0d want=36", q.size()); end
    total++; if (int'(pix_count_o) !== 36) begin bad++; $display("FAIL delta_pix_count got=%0d want=36", pix_count_o); end
    if (q.size() == 36) begin
      total++; if (q[17][7:0] !== 8'd229) begin bad++; $display("FAIL delta_x17 got=%0d want=229", q[17][7:0]); end
      total++; if (q[18][7:0] !== 8'd102) begin bad++; $display("FAIL delta_x18 got=%0d want=102", q[18][7:0]); end
      for (int k = 0; k < 36; k++) begin
        total++; if (q[k] !== model(25, 2867, k)) begin bad++; $display("FAIL delta_pix[%0d] got=%h want=%h", k, q[k], model(25, 2867, k)); end
      end
    end
  endtask

  task automatic test_upscale2;
    logic [23:0] want [4];
    want = '{pix(0), pix(50), pix(100), pix(100)};
    xs[0] = 0;
    xs[1] = 100;
    run_line(2, 16'd2048, 3);
    total++; if (q.size() !== 4) begin bad++; $display("FAIL up2_count got=%0d want=4", q.size()); end
    for (int k = 0; k < 4 && k < q.size(); k++) begin
      total++; if (q[k] !== want[k]) begin bad++; $display("FAIL up2_pix[%0d] got=%h want=%h", k, q[k], want[k]); end
    end
    total++; if (int'(pix_count_o) !== 4) begin bad++; $display("FAIL up2_pix_count got=%0d want=4", pix_count_o); end
  endtask

  task automatic test_round;
    xs[0] = 0;
    xs[1] = 1;
    run_line(2, 16'd2048, 3);
    total++; if (q.size() !== 4) begin bad++; $display("FAIL round_count got=%0d want=4", q.size()); end
    if (q.size() > 1) begin
      total++; if (int'(q[1][7:0]) !== RND / 512) begin bad++; $display("FAIL round_pix1 got=%0d want=%0d", q[1][7:0], RND / 512); end
    end
  endtask

  task automatic test_overflow;
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b want=0", ovf_o); end
    for (int i = 0; i < 4; i++) xs[i] = 10 * i;
    run_line(4, 16'd1024, 0);
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf_o); end
    @(negedge clk);
    vs_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (vs_o !== 1'b0) begin bad++; $display("FAIL vs_delay2 got=%b want=0", vs_o); end
    @(posedge clk);
    #1;
    total++; if (vs_o !== 1'b1) begin bad++; $display("FAIL vs_delay3 got=%b want=1", vs_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", ovf_o); end
    @(negedge clk);
    vs_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_midline_reset;
    for (int i = 0; i < 10; i++) xs[i] = 7 * i;
    scale_step = 16'd4096;
    hs_i = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      di_i = pix(xs[i]);
      de_i = 1'b1;
      @(negedge clk);
      de_i = 1'b0;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    total++; if (do_o !== 24'h0 || de_o !== 1'b0) begin bad++; $display("FAIL mid_rst_data got=%h/%b want=0/0", do_o, de_o); end
    total++; if (hs_o !== 1'b1 || vs_o !== 1'b1) begin bad++; $display("FAIL mid_rst_sync got=%b%b want=11", hs_o, vs_o); end
    total++; if (pix_count_o !== 13'd0 || ovf_o !== 1'b0) begin bad++; $display("FAIL mid_rst_status got=%0d/%b want=0/0", pix_count_o, ovf_o); end
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    for (int i = 5; i < 10; i++) begin
      di_i = pix(xs[i]);
      de_i = 1'b1;
      @(negedge clk);
      de_i = 1'b0;
      @(negedge clk);
    end
    hs_i = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (q.size() !== 0) begin bad++; $display("FAIL mid_partial got=%0d want=0", q.size()); end
    for (int i = 0; i < 6; i++) xs[i] = 40 * i;
    run_line(6, 16'd4096, 1);
    total++; if (q.size() !== 6) begin bad++; $display("FAIL after_rst_count got=%0d want=6", q.size()); end
    for (int k = 0; k < 6 && k < q.size(); k++) begin
      total++; if (q[k] !== pix(40 * k)) begin bad++; $display("FAIL after_rst_pix[%0d] got=%h want=%h", k, q[k], pix(40 * k)); end
    end
    total++; if (int'(pix_count_o) !== 6) begin bad++; $display("FAIL after_rst_pix_count got=%0d want=6", pix_count_o); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ramp();
    test_downscale();
    test_delta();
    test_upscale2();
    test_round();
    test_overflow();
    test_midline_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
